// File: rtl/smoldvi_pixel_fifo.sv
// smoldvi_pixel_fifo: first-word-fall-through pixel FIFO feeding the DVI output stage,
// presenting a fixed colour when empty and tracking underruns.
module smoldvi_pixel_fifo #(
  parameter int          DEPTH           = 16,
  parameter logic [23:0] UNDERRUN_COLOUR = 24'h000000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic [23:0]                wdata,
  input  logic                       wvalid,
  output logic                       wready,
  output logic [7:0]                 r,
  output logic [7:0]                 g,
  output logic [7:0]                 b,
  input  logic                       rgb_rdy,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       underrun,
  input  logic                       underrun_clr,
  output logic [15:0]                underrun_count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  logic [23:0] mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0] level_q, level_d;
  logic [15:0] cnt_q, cnt_d;
  logic und_q, und_d, push, pop, ev;
  assign wready = (level_q != FULL) && !rst;
  always_comb begin
    push = wvalid && wready && !flush;
    pop = rgb_rdy && (level_q != '0) && !flush;
    ev = rgb_rdy && (level_q == '0) && !flush;
    level_d = flush ? '0 : level_q + (AW+1)'(push) - (AW+1)'(pop);
    und_d = ev || (und_q && !underrun_clr);
    cnt_d = ev ? (underrun_clr ? 16'd1 : cnt_q + 16'(cnt_q != 16'hffff)) : underrun_clr ? '0 : cnt_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      level_q <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      und_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      level_q <= level_d;
      wptr_q <= wptr_q + AW'(push);
      rptr_q <= flush ? wptr_q : rptr_q + AW'(pop);
      und_q <= und_d;
      cnt_q <= cnt_d;
    end
  // storage needs no reset: the head is masked by level whenever the FIFO is empty
  always_ff @(posedge clk)
    if (push) mem_q[wptr_q] <= wdata;
  assign {r, g, b} = (level_q != '0) ? mem_q[rptr_q] : UNDERRUN_COLOUR;
  assign level = level_q;
  assign underrun = und_q;
  assign underrun_count = cnt_q;
endmodule

// File: tb/tb_smoldvi_pixel_fifo.sv
// tb_smoldvi_pixel_fifo: directed stimulus with a queue scoreboard; a negedge monitor
// checks every consumed pixel and tracks the expected underrun state.
module tb_smoldvi_pixel_fifo;
  localparam int DEPTH = 16;
  localparam logic [23:0] COL = 24'h000000;
  logic clk = 0, rst = 1, flush = 0, wvalid = 0, rgb_rdy = 0, underrun_clr = 0;
  logic [23:0] wdata = '0;
  logic wready, underrun;
  logic [7:0] r, g, b;
  logic [4:0] level;
  logic [15:0] underrun_count;
  logic [23:0] q[$];
  int nvec = 0, nerr = 0, npop = 0;
  logic eu = 0, ev_m;
  logic [15:0] ec = 0;
  smoldvi_pixel_fifo #(.DEPTH(DEPTH), .UNDERRUN_COLOUR(COL)) dut (
    .clk(clk), .rst(rst), .flush(flush), .wdata(wdata), .wvalid(wvalid), .wready(wready),
    .r(r), .g(g), .b(b), .rgb_rdy(rgb_rdy), .level(level), .underrun(underrun),
    .underrun_clr(underrun_clr), .underrun_count(underrun_count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk)
    if (rst) begin
      eu = 0;
      ec = 0;
    end else begin
      ev_m = 0;
      if (rgb_rdy && !flush) begin
        if (q.size() != 0) begin
          chk("pop_data", {8'h0, r, g, b}, {8'h0, q.pop_front()});
          npop++;
        end else begin
          chk("underrun_colour", {8'h0, r, g, b}, {8'h0, COL});
          ev_m = 1;
        end
      end
      if (ev_m) begin
        eu = 1;
        ec = underrun_clr ? 16'd1 : (ec == 16'hffff ? ec : ec + 16'd1);
      end else if (underrun_clr) begin
        eu = 0;
        ec = 0;
      end
    end
  task automatic step(input logic wv, input logic [23:0] wd, input logic rr,
                      input logic fl, input logic clr, output logic acc);
    wvalid = wv; wdata = wd; rgb_rdy = rr; flush = fl; underrun_clr = clr;
    acc = wv && !fl && (q.size() < DEPTH);
    @(posedge clk);
    if (fl) q.delete();
    else if (acc) q.push_back(wd);
    #1;
    wvalid = 0; rgb_rdy = 0; flush = 0; underrun_clr = 0;
  endtask
  task automatic state_chk(input string tag);
    chk({tag, "_level"}, 32'(level), 32'(q.size()));
    chk({tag, "_wready"}, 32'(wready), 32'(q.size() < DEPTH));
    chk({tag, "_rgb"}, {8'h0, r, g, b}, {8'h0, q.size() != 0 ? q[0] : COL});
    chk({tag, "_underrun"}, 32'(underrun), 32'(eu));
    chk({tag, "_count"}, 32'(underrun_count), 32'(ec));
  endtask
  initial begin
    logic a;
    int i, c;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_level", 32'(level), 0);
    chk("rst_wready", 32'(wready), 0);
    chk("rst_rgb", {8'h0, r, g, b}, {8'h0, COL});
    chk("rst_underrun", 32'(underrun), 0);
    rst = 0;
    #1;
    chk("post_rst_wready", 32'(wready), 1);
    // two pushes, then consume the head
    step(1, 24'h112233, 0, 0, 0, a);
    step(1, 24'h445566, 0, 0, 0, a);
    chk("two_level", 32'(level), 2);
    chk("two_rgb", {8'h0, r, g, b}, 32'h112233);
    step(0, 0, 1, 0, 0, a);
    chk("after_pop_rgb", {8'h0, r, g, b}, 32'h445566);
    chk("after_pop_level", 32'(level), 1);
    step(0, 0, 1, 0, 0, a);
    state_chk("drain1");
    // fill to full, then a write held during a pop must be refused
    for (int k = 0; k < DEPTH; k++) step(1, 24'h000100 + 24'(k), 0, 0, 0, a);
    chk("full_level", 32'(level), 16);
    chk("full_wready", 32'(wready), 0);
    step(1, 24'hdeadbe, 1, 0, 0, a);
    chk("full_pop_level", 32'(level), 15);
    chk("full_pop_wready", 32'(wready), 1);
    while (q.size() != 0) step(0, 0, 1, 0, 0, a);
    state_chk("drain2");
    // underrun with a simultaneous push
    step(1, 24'haabbcc, 1, 0, 0, a);
    chk("ur_flag", 32'(underrun), 1);
    chk("ur_count", 32'(underrun_count), 1);
    chk("ur_level", 32'(level), 1);
    chk("ur_rgb", {8'h0, r, g, b}, 32'haabbcc);
    step(0, 0, 1, 0, 1, a);
    state_chk("ur_clr");
    // ramp streamed through with alternating consume pulses, across pointer wrap
    i = 0;
    c = 0;
    npop = 0;
    while ((i < 40 || q.size() != 0) && c < 400) begin
      step(i < 40, 24'(i), c[0] && q.size() != 0, 0, 0, a);
      if (a) i++;
      c++;
    end
    chk("ramp_popped", npop, 40);
    state_chk("ramp_end");
    // saturate the underrun counter
    for (int k = 0; k < 65535; k++) step(0, 0, 1, 0, 0, a);
    chk("sat_count", 32'(underrun_count), 32'hffff);
    step(0, 0, 1, 0, 0, a);
    chk("sat_hold", 32'(underrun_count), 32'hffff);
    step(0, 0, 1, 0, 1, a);
    chk("clr_vs_event_count", 32'(underrun_count), 1);
    chk("clr_vs_event_flag", 32'(underrun), 1);
    // flush overrides push/pop and leaves underrun alone
    for (int k = 0; k < 5; k++) step(1, 24'h500000 + 24'(k), 0, 0, 0, a);
    chk("pre_flush_level", 32'(level), 5);
    step(1, 24'h777777, 1, 1, 0, a);
    chk("flush_level", 32'(level), 0);
    chk("flush_rgb", {8'h0, r, g, b}, {8'h0, COL});
    chk("flush_underrun", 32'(underrun), 1);
    chk("flush_count", 32'(underrun_count), 1);
    step(1, 24'h123456, 0, 0, 0, a);
    step(0, 0, 1, 0, 0, a);
    state_chk("post_flush");
    // asynchronous reset mid-stream
    for (int k = 0; k < 3; k++) step(1, 24'h600000 + 24'(k), 0, 0, 0, a);
    rst = 1;
    #1;
    q.delete();
    chk("async_rst_level", 32'(level), 0);
    chk("async_rst_wready", 32'(wready), 0);
    chk("async_rst_rgb", {8'h0, r, g, b}, {8'h0, COL});
    chk("async_rst_underrun", 32'(underrun), 0);
    chk("async_rst_count", 32'(underrun_count), 0);
    @(posedge clk);
    #1;
    rst = 0;
    #1;
    chk("rst2_wready", 32'(wready), 1);
    step(1, 24'h0a0b0c, 0, 0, 0, a);
    step(0, 0, 1, 0, 0, a);
    state_chk("final");
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
